// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Writable instruction memory with a byte-serial program-load port.
// A host pulses start_i, sends a word count N, then 4*N big-endian bytes.
// These bytes are packed into 32-bit words and stored at word addresses 0..N-1.
// The CPU is held in reset (cpu_rst_o=1) until a load completes.
// After that, fetches are served combinationally.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            one-cycle pulse starting a load (honoured in IDLE/DONE)
//   byte_i             load data byte
//   byte_valid_i       byte_i valid this cycle
//   byte_ready_o       byte accepted when byte_valid_i && byte_ready_o
//   busy_o             load in progress
//   done_o             load complete, memory valid
//   err_o              last load rejected (count too large), sticky
//   cpu_rst_o          CPU reset request
//   word_cnt_o         words written by the current/last load
//   pc_addr_i          CPU byte address
//   instr_o            instruction word (0 while cpu_rst_o=1)
module instr_mem_loader #(
  parameter int MEM_DEPTH = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cpu_rst_o,
  output logic [ADDR_W:0]   word_cnt_o,
  input  logic [31:0]       pc_addr_i,
  output logic [31:0]       instr_o
);

  typedef enum logic [1:0] {IDLE, COUNT, DATA, DONE} state_t;

  localparam logic [7:0] MAX_N = 8'(MEM_DEPTH);

  state_t            state_reg;
  logic [ADDR_W:0]   n_reg;
  logic [ADDR_W:0]   word_cnt_reg;
  logic [1:0]        byte_cnt_reg;
  logic [23:0]       shift_reg;
  logic              err_reg;
  logic [31:0]       mem_reg [MEM_DEPTH];

  logic              accept;
  logic              mem_clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_cnt_inc;

  // Status outputs decode directly from the state register.
  assign byte_ready_o = (state_reg == COUNT) || (state_reg == DATA);
  assign busy_o       = byte_ready_o;
  assign done_o       = (state_reg == DONE);
  assign cpu_rst_o    = (state_reg != DONE);
  assign err_o        = err_reg;
  assign word_cnt_o   = word_cnt_reg;

  assign accept       = byte_valid_i && byte_ready_o;
  assign mem_clear    = ((state_reg == IDLE) || (state_reg == DONE)) && start_i;
  // The number of words already written is also the next write address.
  // When N=MEM_DEPTH, the address wraps after the final write, and no further
  // write follows.
  assign wr_addr      = word_cnt_reg[ADDR_W-1:0];
  assign wr_data      = {shift_reg, byte_i};
  assign wr_en        = (state_reg == DATA) && accept && (byte_cnt_reg == 2'd3);
  assign word_cnt_inc = word_cnt_reg + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      n_reg        <= '0;
      word_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start_i) begin
            state_reg    <= COUNT;
            n_reg        <= '0;
            word_cnt_reg <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
            err_reg      <= 1'b0;
          end
        end
        COUNT: begin
          if (accept) begin
            if (byte_i == 8'd0) begin
              state_reg <= DONE;
            end else if (byte_i > MAX_N) begin
              err_reg   <= 1'b1;
              state_reg <= IDLE;
            end else begin
              n_reg     <= byte_i[ADDR_W:0];
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            if (byte_cnt_reg == 2'd3) begin
              // The fourth byte completes the word. The memory write happens
              // in the per-word blocks below.
              byte_cnt_reg <= '0;
              word_cnt_reg <= word_cnt_inc;
              if (word_cnt_inc == n_reg)
                state_reg <= DONE;
            end else begin
              shift_reg    <= {shift_reg[15:0], byte_i};
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The memory must be cleared in a single cycle on reset or on start.
  // For that reason, each word is an independent register rather than
  // a RAM block.
  genvar gi;
  generate
    for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
      localparam logic [ADDR_W-1:0] IDX = gi;
      always_ff @(posedge clk_i) begin
        if (rst_i || mem_clear)
          mem_reg[gi] <= '0;
        else if (wr_en && (wr_addr == IDX))
          mem_reg[gi] <= wr_data;
      end
    end
  endgenerate

  // Fetch path: word index from pc bits [ADDR_W+1:2].
  // The byte offset and the high bits do not take part in the fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_addr_i[31:ADDR_W+2], pc_addr_i[1:0]};

  assign instr_o = cpu_rst_o ? 32'd0 : mem_reg[pc_addr_i[ADDR_W+1:2]];

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writable instruction memory with a byte-serial program-load port. It is the write side of the CPU's instruction fetch path: a host streams a word count and then instruction bytes, which are assembled into 32-bit words and stored at consecutive word addresses from 0. While a load is in progress the block holds the CPU in reset. After the load completes it serves combinational fetches indexed by pc_addr_i/4.

Parameters:
MEM_DEPTH, 32, number of 32-bit instruction words.
ADDR_W, 5, word-address width (log2 MEM_DEPTH).

Ports:
clk_i  input  1  system clock; all state updates on its rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  one-cycle pulse that begins a load
byte_i  input  8  load data byte
byte_valid_i  input  1  byte_i is valid this cycle
byte_ready_o  output  1  block will accept byte_i this cycle
busy_o  output  1  load in progress (COUNT or DATA)
done_o  output  1  load complete; memory is valid
err_o  output  1  last load was rejected (bad count); sticky until the next start or reset
cpu_rst_o  output  1  CPU reset request, active-high
word_cnt_o  output  ADDR_W+1  number of words written by the current or last load
pc_addr_i  input  32  CPU byte address
instr_o  output  32  instruction word

Behaviour:
- Reset is synchronous, active-high on rst_i at a clk_i edge, and overrides everything, including mid-load. Reset values:
  - state=IDLE, all MEM_DEPTH words cleared to 0.
  - byte_ready_o=0, busy_o=0, done_o=0, err_o=0, cpu_rst_o=1, word_cnt_o=0.
  - Internal byte counter and shift register cleared to 0.
- A byte is accepted only on a cycle where byte_valid_i and byte_ready_o are both 1. byte_ready_o=1 only in COUNT and DATA. Bytes offered in other states are ignored and consume nothing.
- IDLE:
  - start_i moves to COUNT and clears err_o, done_o, word_cnt_o, all memory words and the byte counter.
  - cpu_rst_o=1.
- COUNT: the first accepted byte is N.
  - N==0: go to DONE with 0 words written.
  - 1<=N<=MEM_DEPTH: store N and go to DATA.
  - N>MEM_DEPTH: set err_o=1, go to IDLE, memory stays all-zero.
- DATA: bytes are big-endian; the first byte of each word is bits [31:24].
  - Bytes 1-3 of a word shift into a 24-bit register.
  - On byte 4, write {shift[23:0], byte_i} to mem[wr_addr] in that same cycle, then increment wr_addr and word_cnt_o.
  - When word_cnt_o reaches N, go to DONE in the next cycle.
  - Partial words are never written.
- DONE:
  - cpu_rst_o=0, done_o=1.
  - start_i returns to COUNT with the same clearing as from IDLE, and cpu_rst_o returns to 1 on the next cycle.
- start_i during COUNT or DATA is ignored.
- busy_o is 1 exactly in COUNT and DATA.
- Fetch path:
  - instr_o = mem[pc_addr_i[ADDR_W+1:2]], combinational, no clock latency.
  - pc_addr_i[1:0] and the high bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
  - instr_o = 0 (NOP) whenever cpu_rst_o=1, so no fetch observes a partially loaded memory.
- No backpressure beyond byte_ready_o. One byte can be accepted per cycle, so a full load takes 1+4N accepted bytes.
- word_cnt_o holds its value after DONE or an error until the next start or reset.

Test Plan:
- Reset then idle: assert rst_i for 2 cycles -> cpu_rst_o=1, done_o=0, byte_ready_o=0, instr_o=0 for pc_addr_i=0; bytes offered with byte_valid_i=1 are not accepted.
- Two-word load:
  - Stimulus: start_i, then bytes 02, 20,08,00,05, 8C,01,00,04 on consecutive cycles.
  - Response: done_o=1 and cpu_rst_o=0 one cycle after the last byte; word_cnt_o=2.
  - Fetch: pc_addr_i=0 -> 32'h20080005; pc_addr_i=4 -> 32'h8C010004; pc_addr_i=8 -> 0; pc_addr_i=32'h81 -> 32'h20080005 (wrap and misalignment).
- Valid gaps: same load with byte_valid_i low on alternate cycles -> identical memory contents; busy_o stays 1 throughout.
- Bad count: start_i, byte 21 (33) -> err_o=1, state IDLE, done_o=0, cpu_rst_o=1; a following start_i clears err_o.
- Zero count: start_i, byte 00 -> done_o=1, word_cnt_o=0, every fetch returns 0.
- Reset and restart:
  - rst_i asserted after 5 data bytes of an N=3 load -> all memory 0, state IDLE.
  - After a completed load, start_i with N=1 and word 32'hFFFFFFFF -> cpu_rst_o=1 during the load; afterwards mem[0]=FFFFFFFF and mem[1]=0 (cleared).
